clock_alarm_ctrl: RTL and testbench

Consumes the raw clock-loss indication from the clock checker and turns it into a clean, software-visible alarm, running on the always-present management clock I_clock. It synchronises the asynchronous loss flag, filters glitches with a programmable persistence window, and runs a four-state assert/deassert state machine. It also holds a sticky alarm with a maskable interrupt and counts loss events for the status register block.

---
 rtl/clock_alarm_pkg.sv | 16 +
 rtl/clock_alarm_sync.sv | 26 ++
 rtl/clock_alarm_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_alarm_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_alarm_pkg.sv
// Shared types and default sizing for the clock-loss alarm controller.
// Optional event counter is enabled by defining CLOCK_ALARM_CNT_EN.
package clock_alarm_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_W      = 8;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        ASSERT_PEND = 2'd1,
        ALARM       = 2'd2,
        CLEAR_PEND  = 2'd3
    } alarm_state_e;

endpackage

// File: rtl/clock_alarm_sync.sv
// Multi-flop single-bit synchroniser into the management clock domain.
// Flops reset to 0 so a stale loss flag never survives reset.
module clock_alarm_sync
    import clock_alarm_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic I_clock,
    input  logic I_reset_n,
    input  logic I_d,
    output logic O_q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], I_d};
        end
    end

    assign O_q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Clock-loss alarm: synchronise, persistence-filter, sticky + interrupt.
// Define CLOCK_ALARM_CNT_EN to build the saturating loss event counter.
module clock_alarm_ctrl
    import clock_alarm_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_W      = DEF_FILT_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              I_clock,
    input  logic              I_reset_n,
    input  logic              I_clock_lose,
    input  logic [FILT_W-1:0] I_filt_len,
    input  logic              I_alarm_clr,
    input  logic              I_cnt_clr,
    input  logic              I_int_mask,
    output logic              O_alarm_state,
    output logic              O_alarm_sticky,
    output logic              O_int,
    output logic [CNT_W-1:0]  O_lose_cnt
);

    localparam logic [1:0] S_NORMAL      = NORMAL;
    localparam logic [1:0] S_ASSERT_PEND = ASSERT_PEND;
    localparam logic [1:0] S_ALARM       = ALARM;
    localparam logic [1:0] S_CLEAR_PEND  = CLEAR_PEND;

    logic              lose_s;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [FILT_W-1:0] fcnt_q;
    logic              window_done;
    logic              loss_event;
    logic              sticky_q;
    logic              int_q;

    clock_alarm_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lose_sync (
        .I_clock   (I_clock),
        .I_reset_n (I_reset_n),
        .I_d       (I_clock_lose),
        .O_q       (lose_s)
    );

    // Window length is read live so a reprogram applies without restart.
    assign window_done = (fcnt_q >= I_filt_len);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NORMAL: begin
                if (lose_s) state_d = S_ASSERT_PEND;
            end
            S_ASSERT_PEND: begin
                if (!lose_s)          state_d = S_NORMAL;
                else if (window_done) state_d = S_ALARM;
            end
            S_ALARM: begin
                if (!lose_s) state_d = S_CLEAR_PEND;
            end
            S_CLEAR_PEND: begin
                if (lose_s)           state_d = S_ALARM;
                else if (window_done) state_d = S_NORMAL;
            end
            default: state_d = S_NORMAL;
        endcase
    end

    assign loss_event = (state_q == S_ASSERT_PEND) &&
                        (state_d == S_ALARM);

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= S_NORMAL;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q != {FILT_W{1'b1}}) begin
                fcnt_q <= fcnt_q + FILT_W'(1);
            end
        end
    end

    // A new event wins over a clear arriving on the same edge.
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sticky_q <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            if (loss_event) begin
                sticky_q <= 1'b1;
            end else if (I_alarm_clr) begin
                sticky_q <= 1'b0;
            end
            int_q <= sticky_q & ~I_int_mask;
        end
    end

`ifdef CLOCK_ALARM_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            cnt_q <= '0;
        end else if (loss_event) begin
            if (I_cnt_clr) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (I_cnt_clr) begin
            cnt_q <= '0;
        end
    end

    assign O_lose_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = I_cnt_clr;
    assign O_lose_cnt     = '0;
`endif

    assign O_alarm_state  = (state_q == S_ALARM) ||
                            (state_q == S_CLEAR_PEND);
    assign O_alarm_sticky = sticky_q;
    assign O_int          = int_q;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Directed bench for clock_alarm_ctrl with a persistence-run reference model.
// Counter expectations follow CLOCK_ALARM_CNT_EN.
module tb_clock_alarm_ctrl;

    localparam int SYNC   = 2;
    localparam int FILT_W = 8;
    localparam int CNT_W  = 4;
`ifdef CLOCK_ALARM_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              lose = 1'b0;
    logic [FILT_W-1:0] filt_len = 8'd4;
    logic              alarm_clr = 1'b0;
    logic              cnt_clr = 1'b0;
    logic              mask = 1'b0;
    logic              o_state;
    logic              o_sticky;
    logic              o_int;
    logic [CNT_W-1:0]  o_cnt;

    int n_cmp = 0;
    int n_err = 0;

    clock_alarm_ctrl #(
        .SYNC_STAGES (SYNC),
        .FILT_W      (FILT_W),
        .CNT_W       (CNT_W)
    ) dut (
        .I_clock        (clk),
        .I_reset_n      (rst_n),
        .I_clock_lose   (lose),
        .I_filt_len     (filt_len),
        .I_alarm_clr    (alarm_clr),
        .I_cnt_clr      (cnt_clr),
        .I_int_mask     (mask),
        .O_alarm_state  (o_state),
        .O_alarm_sticky (o_sticky),
        .O_int          (o_int),
        .O_lose_cnt     (o_cnt)
    );

    always #5 clk = ~clk;

    // Model: alarm flips once the synchronised flag has disagreed with it
    // for filt_len+2 consecutive edges; any agreement restarts the run.
    logic [SYNC-1:0] m_sh;
    int              m_run;
    logic            m_alarm;
    logic            m_sticky;
    logic            m_int;
    int              m_cnt;

    always @(posedge clk or negedge rst_n) begin
        logic s;
        logic evt;
        if (!rst_n) begin
            m_sh     = '0;
            m_run    = 0;
            m_alarm  = 1'b0;
            m_sticky = 1'b0;
            m_int    = 1'b0;
            m_cnt    = 0;
        end else begin
            s     = m_sh[SYNC-1];
            m_sh  = {m_sh[SYNC-2:0], lose};
            m_int = m_sticky & ~mask;
            evt   = 1'b0;
            if (s != m_alarm) begin
                m_run++;
                if (m_run >= int'(filt_len) + 2) begin
                    m_alarm = s;
                    m_run   = 0;
                    evt     = s;
                end
            end else begin
                m_run = 0;
            end
            if (evt)            m_sticky = 1'b1;
            else if (alarm_clr) m_sticky = 1'b0;
            if (CNT_EN) begin
                if (evt)          m_cnt = cnt_clr ? 1 : (m_cnt < 15 ? m_cnt + 1 : 15);
                else if (cnt_clr) m_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_state",  int'(o_state),  int'(m_alarm));
        check("model_sticky", int'(o_sticky), int'(m_sticky));
        check("model_int",    int'(o_int),    int'(m_int));
        check("model_cnt",    int'(o_cnt),    m_cnt);
    end

    task automatic wait_state(input logic val, input int max, output int edges);
        edges = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (o_state === val) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int e;
        repeat (3) @(negedge clk);
        check("rst_state",  int'(o_state),  0);
        check("rst_sticky", int'(o_sticky), 0);
        check("rst_int",    int'(o_int),    0);
        check("rst_cnt",    int'(o_cnt),    0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // short pulse is filtered
        lose = 1'b1;
        repeat (3) @(negedge clk);
        lose = 1'b0;
        repeat (12) @(negedge clk);
        check("pulse_state",  int'(o_state),  0);
        check("pulse_sticky", int'(o_sticky), 0);
        check("pulse_cnt",    int'(o_cnt),    0);

        // held loss: assert latency
        lose = 1'b1;
        wait_state(1'b1, 20, e);
        check("assert_lat", e, 8);
        check("assert_cnt", int'(o_cnt), CNT_EN ? 1 : 0);
        check("assert_sticky", int'(o_sticky), 1);
        check("int_before", int'(o_int), 0);
        @(posedge clk);
        #1;
        check("int_after", int'(o_int), 1);
        @(negedge clk);
        lose = 1'b0;
        wait_state(1'b0, 20, e);
        check("deassert_lat", e, 8);

        // re-assert during clear window: no new event
        @(negedge clk);
        lose = 1'b1;
        wait_state(1'b1, 20, e);
        @(negedge clk);
        lose = 1'b0;
        repeat (4) @(negedge clk);
        lose = 1'b1;
        repeat (8) @(negedge clk);
        check("reenter_state", int'(o_state), 1);
        check("reenter_cnt", int'(o_cnt), CNT_EN ? 2 : 0);
        lose = 1'b0;
        repeat (10) @(negedge clk);

        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        check("clr_sticky", int'(o_sticky), 0);
        @(negedge clk);
        check("clr_int", int'(o_int), 0);

        // clear pulses coincide with the event edge (filt_len=0)
        filt_len = 8'd0;
        lose = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        alarm_clr = 1'b1;
        cnt_clr   = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        cnt_clr   = 1'b0;
        check("same_edge_state",  int'(o_state),  1);
        check("same_edge_sticky", int'(o_sticky), 1);
        check("same_edge_cnt",    int'(o_cnt),    CNT_EN ? 1 : 0);

        mask = 1'b1;
        repeat (2) @(negedge clk);
        check("mask_int",    int'(o_int),    0);
        check("mask_sticky", int'(o_sticky), 1);
        mask = 1'b0;
        repeat (2) @(negedge clk);
        check("unmask_int", int'(o_int), 1);
        lose = 1'b0;
        wait_state(1'b0, 20, e);
        check("fast_deassert_lat", e, 4);

        // saturation
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            lose = 1'b1;
            wait_state(1'b1, 20, e);
            lose = 1'b0;
            wait_state(1'b0, 20, e);
        end
        @(negedge clk);
        check("sat_cnt", int'(o_cnt), CNT_EN ? 15 : 0);

        // reset while in alarm with loss held
        filt_len = 8'd4;
        lose = 1'b1;
        wait_state(1'b1, 20, e);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state",  int'(o_state),  0);
        check("mid_rst_sticky", int'(o_sticky), 0);
        check("mid_rst_int",    int'(o_int),    0);
        check("mid_rst_cnt",    int'(o_cnt),    0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state(1'b1, 20, e);
        check("post_rst_lat", e, 8);
        check("post_rst_cnt", int'(o_cnt), CNT_EN ? 1 : 0);
        lose = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
